// File: rtl/alu_op_issue_if.sv
// rtl/alu_op_issue_if.sv - ID->EX issue stage bus: decode inputs, hazard controls, registered ALU operands
interface alu_op_issue_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic [31:0]      in_instr;
   logic [WIDTH-1:0] in_rs_data;
   logic [WIDTH-1:0] in_rt_data;
   logic             stall;
   logic             flush;
   logic             out_valid;
   logic [3:0]       out_alu_ctr;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [4:0]       out_wr_addr;
   logic             out_reg_write;
   logic             out_illegal;

   modport master (
      output in_valid, in_instr, in_rs_data, in_rt_data, stall, flush,
      input  out_valid, out_alu_ctr, out_a, out_b, out_wr_addr, out_reg_write, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_rs_data, in_rt_data, stall, flush,
      output out_valid, out_alu_ctr, out_a, out_b, out_wr_addr, out_reg_write, out_illegal
   );
endinterface

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - decodes a MIPS instruction into ALU control/operands held in the ID/EX register
module alu_op_issue #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic          clk,
   input logic          rst,
   alu_op_issue_if.slave bus
);
   localparam logic [3:0] ALU_ADDU = 4'b0000;
   localparam logic [3:0] ALU_SUBU = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_NOR  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_LUI  = 4'b1011;

   logic [5:0]       op;
   logic [5:0]       funct;
   logic [4:0]       rt_idx;
   logic [4:0]       rd_idx;
   logic [15:0]      imm;
   logic [WIDTH-1:0] imm_sext;
   logic [WIDTH-1:0] imm_zext;
   logic [WIDTH-1:0] shamt_imm;
   logic [WIDTH-1:0] shamt_reg;

   logic [3:0]       d_ctr;
   logic [WIDTH-1:0] d_a;
   logic [WIDTH-1:0] d_b;
   logic [4:0]       d_wr;
   logic             d_rw;
   logic             d_ill;

   assign op        = bus.in_instr[31:26];
   assign funct     = bus.in_instr[5:0];
   assign rt_idx    = bus.in_instr[20:16];
   assign rd_idx    = bus.in_instr[15:11];
   assign imm       = bus.in_instr[15:0];
   assign imm_sext  = {{(WIDTH-16){imm[15]}}, imm};
   assign imm_zext  = {{(WIDTH-16){1'b0}}, imm};
   assign shamt_imm = {{(WIDTH-SHAMT_W){1'b0}}, bus.in_instr[6+SHAMT_W-1:6]};
   assign shamt_reg = {{(WIDTH-SHAMT_W){1'b0}}, bus.in_rs_data[SHAMT_W-1:0]};

   always_comb begin
      d_ctr = ALU_ADDU;
      d_a   = '0;
      d_b   = '0;
      d_wr  = '0;
      d_rw  = 1'b0;
      d_ill = 1'b0;
      if (op == 6'b000000) begin
         d_a  = bus.in_rs_data;
         d_b  = bus.in_rt_data;
         d_wr = rd_idx;
         d_rw = 1'b1;
         case (funct)
            6'b100000, 6'b100001: d_ctr = ALU_ADDU;
            6'b100010, 6'b100011: d_ctr = ALU_SUBU;
            6'b100100: d_ctr = ALU_AND;
            6'b100101: d_ctr = ALU_OR;
            6'b100110: d_ctr = ALU_XOR;
            6'b100111: d_ctr = ALU_NOR;
            6'b101010: d_ctr = ALU_SLT;
            6'b101011: d_ctr = ALU_SLTU;
            6'b000000: begin d_ctr = ALU_SLL; d_a = shamt_imm; end
            6'b000010: begin d_ctr = ALU_SRL; d_a = shamt_imm; end
            6'b000011: begin d_ctr = ALU_SRA; d_a = shamt_imm; end
            6'b000100: begin d_ctr = ALU_SLL; d_a = shamt_reg; end
            6'b000110: begin d_ctr = ALU_SRL; d_a = shamt_reg; end
            6'b000111: begin d_ctr = ALU_SRA; d_a = shamt_reg; end
            6'b001000: begin d_wr = '0; d_rw = 1'b0; end
            default: begin
               d_a   = '0;
               d_b   = '0;
               d_wr  = '0;
               d_rw  = 1'b0;
               d_ill = 1'b1;
            end
         endcase
      end else begin
         d_a  = bus.in_rs_data;
         d_wr = rt_idx;
         d_rw = 1'b1;
         case (op)
            6'b001000, 6'b001001, 6'b100011: begin d_ctr = ALU_ADDU; d_b = imm_sext; end
            6'b001010: begin d_ctr = ALU_SLT;  d_b = imm_sext; end
            6'b001011: begin d_ctr = ALU_SLTU; d_b = imm_sext; end
            6'b001100: begin d_ctr = ALU_AND;  d_b = imm_zext; end
            6'b001101: begin d_ctr = ALU_OR;   d_b = imm_zext; end
            6'b001110: begin d_ctr = ALU_XOR;  d_b = imm_zext; end
            // the ALU performs the <<16 itself, so B carries the raw immediate
            6'b001111: begin d_ctr = ALU_LUI;  d_b = imm_zext; end
            6'b101011: begin d_ctr = ALU_ADDU; d_b = imm_sext; d_wr = '0; d_rw = 1'b0; end
            6'b000100, 6'b000101: begin
               d_ctr = ALU_SUBU;
               d_b   = bus.in_rt_data;
               d_wr  = '0;
               d_rw  = 1'b0;
            end
            default: begin
               d_a   = '0;
               d_wr  = '0;
               d_rw  = 1'b0;
               d_ill = 1'b1;
            end
         endcase
      end
   end

   // flush behaves exactly like reset on the register, and both override stall
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         bus.out_valid     <= 1'b0;
         bus.out_alu_ctr   <= '0;
         bus.out_a         <= '0;
         bus.out_b         <= '0;
         bus.out_wr_addr   <= '0;
         bus.out_reg_write <= 1'b0;
         bus.out_illegal   <= 1'b0;
      end else if (!bus.stall) begin
         bus.out_valid     <= bus.in_valid;
         bus.out_alu_ctr   <= d_ctr;
         bus.out_a         <= d_a;
         bus.out_b         <= d_b;
         bus.out_wr_addr   <= d_wr;
         bus.out_reg_write <= bus.in_valid && d_rw && (d_wr != 5'd0);
         bus.out_illegal   <= bus.in_valid && d_ill;
      end
   end
endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - scoreboard bench for the ID->EX ALU issue stage
module tb_alu_op_issue;
   typedef struct packed {
      logic        valid;
      logic [3:0]  ctr;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  wr;
      logic        rw;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs;
      logic [31:0] rt;
      exp_t        e;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   exp_t sb_exp[$];
   exp_t sb_msk[$];
   exp_t got, ex, mk;

   always #5 clk = ~clk;

   alu_op_issue_if #(.WIDTH(32)) bus ();

   alu_op_issue #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic exp_t mk_e(logic v, logic [3:0] c, logic [31:0] a, logic [31:0] b,
                                 logic [4:0] w, logic r, logic i);
      exp_t e;
      e.valid = v; e.ctr = c; e.a = a; e.b = b; e.wr = w; e.rw = r; e.ill = i;
      return e;
   endfunction

   function automatic exp_t full_mask();
      exp_t m;
      m = '1;
      return m;
   endfunction

   function automatic exp_t bubble_mask();
      exp_t m;
      m = '0; m.valid = 1'b1; m.rw = 1'b1; m.ill = 1'b1;
      return m;
   endfunction

   function automatic exp_t sample();
      return mk_e(bus.out_valid, bus.out_alu_ctr, bus.out_a, bus.out_b,
                  bus.out_wr_addr, bus.out_reg_write, bus.out_illegal);
   endfunction

   function automatic string fmt(exp_t e);
      return $sformatf("v=%0b ctr=%b a=%h b=%h wr=%0d rw=%0b ill=%0b",
                       e.valid, e.ctr, e.a, e.b, e.wr, e.rw, e.ill);
   endfunction

   // reference decode written straight from the instruction table
   function automatic exp_t model(logic v, logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
      exp_t e;
      logic [5:0]  op, fn;
      logic [31:0] sx, zx;
      op = ins[31:26]; fn = ins[5:0];
      sx = {{16{ins[15]}}, ins[15:0]};
      zx = {16'h0000, ins[15:0]};
      e = mk_e(v, 4'h0, rs, rt, ins[15:11], 1'b1, 1'b0);
      if (op == 6'h00) begin
         case (fn)
            6'h20, 6'h21: e.ctr = 4'h0;
            6'h22, 6'h23: e.ctr = 4'h1;
            6'h24: e.ctr = 4'h3;
            6'h25: e.ctr = 4'h5;
            6'h26: e.ctr = 4'h6;
            6'h27: e.ctr = 4'h4;
            6'h2a: e.ctr = 4'h2;
            6'h2b: e.ctr = 4'h9;
            6'h00: begin e.ctr = 4'h7; e.a = {27'h0, ins[10:6]}; end
            6'h02: begin e.ctr = 4'h8; e.a = {27'h0, ins[10:6]}; end
            6'h03: begin e.ctr = 4'ha; e.a = {27'h0, ins[10:6]}; end
            6'h04: begin e.ctr = 4'h7; e.a = {27'h0, rs[4:0]}; end
            6'h06: begin e.ctr = 4'h8; e.a = {27'h0, rs[4:0]}; end
            6'h07: begin e.ctr = 4'ha; e.a = {27'h0, rs[4:0]}; end
            6'h08: begin e.wr = 5'd0; e.rw = 1'b0; end
            default: e = mk_e(v, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
         endcase
      end else begin
         e.wr = ins[20:16];
         case (op)
            6'h08, 6'h09, 6'h23: e.b = sx;
            6'h0a: begin e.ctr = 4'h2; e.b = sx; end
            6'h0b: begin e.ctr = 4'h9; e.b = sx; end
            6'h0c: begin e.ctr = 4'h3; e.b = zx; end
            6'h0d: begin e.ctr = 4'h5; e.b = zx; end
            6'h0e: begin e.ctr = 4'h6; e.b = zx; end
            6'h0f: begin e.ctr = 4'hb; e.b = zx; end
            6'h2b: begin e.b = sx; e.wr = 5'd0; e.rw = 1'b0; end
            6'h04, 6'h05: begin e.ctr = 4'h1; e.wr = 5'd0; e.rw = 1'b0; end
            default: e = mk_e(v, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
         endcase
      end
      if (e.wr == 5'd0) e.rw = 1'b0;
      if (!v) begin e.rw = 1'b0; e.ill = 1'b0; end
      return e;
   endfunction

   task automatic drive(logic v, logic [31:0] ins, logic [31:0] rs, logic [31:0] rt,
                        logic st, logic fl);
      bus.in_valid = v; bus.in_instr = ins; bus.in_rs_data = rs; bus.in_rt_data = rt;
      bus.stall = st; bus.flush = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 32'h00221821, 32'd5, 32'd7, 1'b0, 1'b0);
      sb_exp.push_back('0); sb_msk.push_back(full_mask());
      tick();
      tick();
      rst = 1'b0;
      got = sample(); ex = sb_exp.pop_front(); mk = sb_msk.pop_front();
      total++;
      if ((got & mk) !== (ex & mk)) begin
         bad++;
         $display("FAIL reset: got %s exp %s", fmt(got), fmt(ex));
      end
   endtask

   task automatic run_table(string name, vec_t t[$]);
      foreach (t[i]) begin
         drive(1'b1, t[i].instr, t[i].rs, t[i].rt, 1'b0, 1'b0);
         sb_exp.push_back(t[i].e); sb_msk.push_back(full_mask());
         tick();
         got = sample(); ex = sb_exp.pop_front(); mk = sb_msk.pop_front();
         total++;
         if ((got & mk) !== (ex & mk)) begin
            bad++;
            $display("FAIL %s[%0d] instr=%h: got %s exp %s", name, i, t[i].instr, fmt(got), fmt(ex));
         end
      end
   endtask

   task automatic test_rtype();
      vec_t t[$];
      t.push_back('{32'h00221821, 32'd5, 32'd7, mk_e(1, 4'h0, 32'd5, 32'd7, 5'd3, 1, 0)});
      t.push_back('{32'h00221823, 32'd3, 32'd5, mk_e(1, 4'h1, 32'd3, 32'd5, 5'd3, 1, 0)});
      t.push_back('{32'h00221827, 32'hF0, 32'h0F, mk_e(1, 4'h4, 32'hF0, 32'h0F, 5'd3, 1, 0)});
      t.push_back('{32'h0022182B, 32'h1, 32'h2, mk_e(1, 4'h9, 32'h1, 32'h2, 5'd3, 1, 0)});
      t.push_back('{32'h00022103, 32'h0, 32'h80000000, mk_e(1, 4'ha, 32'd4, 32'h80000000, 5'd4, 1, 0)});
      t.push_back('{32'h000227C2, 32'h9, 32'h12345678, mk_e(1, 4'h8, 32'd31, 32'h12345678, 5'd4, 1, 0)});
      t.push_back('{32'h00221804, 32'hFFFFFF25, 32'h3, mk_e(1, 4'h7, 32'd5, 32'h3, 5'd3, 1, 0)});
      t.push_back('{32'h03E00008, 32'h400, 32'h9, mk_e(1, 4'h0, 32'h400, 32'h9, 5'd0, 0, 0)});
      run_table("rtype", t);
   endtask

   task automatic test_itype();
      vec_t t[$];
      t.push_back('{32'h2825FFFF, 32'd10, 32'd0, mk_e(1, 4'h2, 32'd10, 32'hFFFFFFFF, 5'd5, 1, 0)});
      t.push_back('{32'h3425FFFF, 32'd10, 32'd0, mk_e(1, 4'h5, 32'd10, 32'h0000FFFF, 5'd5, 1, 0)});
      t.push_back('{32'h3C061234, 32'd9, 32'd0, mk_e(1, 4'hb, 32'd9, 32'h00001234, 5'd6, 1, 0)});
      t.push_back('{32'h8C228000, 32'h100, 32'd0, mk_e(1, 4'h0, 32'h100, 32'hFFFF8000, 5'd2, 1, 0)});
      t.push_back('{32'hAC22FFFC, 32'h200, 32'd7, mk_e(1, 4'h0, 32'h200, 32'hFFFFFFFC, 5'd0, 0, 0)});
      t.push_back('{32'h10220003, 32'd1, 32'd2, mk_e(1, 4'h1, 32'd1, 32'd2, 5'd0, 0, 0)});
      run_table("itype", t);
   endtask

   task automatic test_illegal();
      vec_t t[$];
      t.push_back('{32'hFC000000, 32'd1, 32'd2, mk_e(1, 4'h0, 32'h0, 32'h0, 5'd0, 0, 1)});
      t.push_back('{32'h0022183F, 32'd1, 32'd2, mk_e(1, 4'h0, 32'h0, 32'h0, 5'd0, 0, 1)});
      t.push_back('{32'h00220021, 32'd1, 32'd2, mk_e(1, 4'h0, 32'd1, 32'd2, 5'd0, 0, 0)});
      run_table("illegal", t);
   endtask

   task automatic test_stall_flush();
      exp_t held;
      held = mk_e(1, 4'h0, 32'd5, 32'd7, 5'd3, 1, 0);
      drive(1'b1, 32'h00221821, 32'd5, 32'd7, 1'b0, 1'b0);
      sb_exp.push_back(held); sb_msk.push_back(full_mask());
      for (int c = 0; c < 3; c++) begin
         sb_exp.push_back(held); sb_msk.push_back(full_mask());
      end
      sb_exp.push_back('0); sb_msk.push_back(full_mask());
      for (int c = 0; c < 5; c++) begin
         tick();
         if (c < 3) drive(1'b1, 32'hFC000000 + c, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
         else drive(1'b1, 32'h00221821, 32'd5, 32'd7, 1'b1, 1'b1);
         if (c == 4) break;
         got = sample(); ex = sb_exp.pop_front(); mk = sb_msk.pop_front();
         total++;
         if ((got & mk) !== (ex & mk)) begin
            bad++;
            $display("FAIL stall_flush[%0d]: got %s exp %s", c, fmt(got), fmt(ex));
         end
      end
      got = sample(); ex = sb_exp.pop_front(); mk = sb_msk.pop_front();
      total++;
      if ((got & mk) !== (ex & mk)) begin
         bad++;
         $display("FAIL stall_flush[4]: got %s exp %s", fmt(got), fmt(ex));
      end
   endtask

   task automatic test_bubble_and_rst();
      drive(1'b0, 32'h00221821, 32'd5, 32'd7, 1'b0, 1'b0);
      sb_exp.push_back(mk_e(0, 4'h0, 32'd0, 32'd0, 5'd0, 0, 0)); sb_msk.push_back(bubble_mask());
      tick();
      got = sample(); ex = sb_exp.pop_front(); mk = sb_msk.pop_front();
      total++;
      if ((got & mk) !== (ex & mk)) begin
         bad++;
         $display("FAIL bubble: got %s exp %s", fmt(got), fmt(ex));
      end
      drive(1'b1, 32'h3425FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      drive(1'b1, 32'h00221821, 32'd5, 32'd7, 1'b1, 1'b0);
      sb_exp.push_back('0); sb_msk.push_back(full_mask());
      tick();
      rst = 1'b0;
      got = sample(); ex = sb_exp.pop_front(); mk = sb_msk.pop_front();
      total++;
      if ((got & mk) !== (ex & mk)) begin
         bad++;
         $display("FAIL rst_mid: got %s exp %s", fmt(got), fmt(ex));
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops[$] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c,
                            6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h3f, 6'h02};
      logic [5:0] fns[$] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                            6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h3f};
      exp_t prev_e, prev_m, e, m;
      logic [31:0] ins, rs, rt;
      logic v, st, fl;
      prev_e = '0; prev_m = full_mask();
      for (int i = 0; i < 60; i++) begin
         ins = $urandom();
         ins[31:26] = ops[$urandom_range(0, ops.size() - 1)];
         if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, fns.size() - 1)];
         rs = $urandom(); rt = $urandom();
         v  = ($urandom_range(0, 4) != 0);
         st = ($urandom_range(0, 3) == 0);
         fl = (i == 0) || ($urandom_range(0, 7) == 0);
         drive(v, ins, rs, rt, st, fl);
         if (fl) begin e = '0; m = full_mask(); end
         else if (st) begin e = prev_e; m = prev_m; end
         else begin e = model(v, ins, rs, rt); m = v ? full_mask() : bubble_mask(); end
         sb_exp.push_back(e); sb_msk.push_back(m);
         prev_e = e; prev_m = m;
         tick();
         got = sample(); ex = sb_exp.pop_front(); mk = sb_msk.pop_front();
         total++;
         if ((got & mk) !== (ex & mk)) begin
            bad++;
            $display("FAIL back_to_back[%0d] instr=%h st=%0b fl=%0b: got %s exp %s",
                     i, ins, st, fl, fmt(got), fmt(ex));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      test_reset();
      test_rtype();
      test_itype();
      test_illegal();
      test_stall_flush();
      test_bubble_and_rst();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
